// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: default widths, reset PC and
// FSM state encodings, plus a small alignment helper.
package fetch_ctrl_pkg;

    localparam int          FC_WORD      = 64;
    localparam int          FC_INSTR_LEN = 32;
    localparam logic [63:0] FC_RESET_PC  = 64'd0;
    localparam int          FC_PC_INC    = 4;
    localparam int          FC_BUF_DEPTH = 2;

    // State encodings kept as plain constants so older tooling can share them.
    localparam logic [1:0] FC_IDLE  = 2'd0;
    localparam logic [1:0] FC_RUN   = 2'd1;
    localparam logic [1:0] FC_FAULT = 2'd2;

    // A fetch target is legal only on a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding {pc, instr} pairs between the instruction memory
// response and decode. Flush empties it in one cycle and wins over push.
module fetch_buf #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Pointer and occupancy update; a pop and push in one cycle cancel out.
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && !flush && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // The issuer reserves space before each read, so a full buffer never
    // sees a push without a matching pop.
    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !flush && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one read per cycle to the
// synchronous instruction memory, buffers returning instructions with their
// PC and hands them to decode. Handles redirects, stalls and bad targets.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int               WORD      = FC_WORD,
    parameter int               INSTR_LEN = FC_INSTR_LEN,
    parameter logic [WORD-1:0]  RESET_PC  = WORD'(FC_RESET_PC),
    parameter int               PC_INC    = FC_PC_INC,
    parameter int               BUF_DEPTH = FC_BUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [WORD-1:0]      redirect_pc,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      out_pc,
    output logic [INSTR_LEN-1:0] out_instr,
    output logic                 fault,
    output logic [WORD-1:0]      cur_pc
);

    logic [1:0]                state_q, state_d;
    logic [WORD-1:0]           pc_q, pc_d;
    logic [WORD-1:0]           addr_q, addr_d;
    logic                      inflight_q, inflight_d;
    logic                      squash_q, squash_d;

    logic                      run;
    logic                      redir;
    logic                      bad_target;
    logic                      out_fire;
    logic                      issue;
    logic                      push;
    logic                      flush;
    logic [2:0]                occupancy;
    logic [1:0]                buf_count;
    logic [WORD+INSTR_LEN-1:0] buf_dout;

    assign out_valid = (buf_count != 2'd0);

    // Issue rule, response capture and next-state/PC selection.
    always_comb begin
        run        = (state_q == FC_RUN);
        redir      = run && redirect_valid;
        bad_target = misaligned(redirect_pc[1:0]);
        out_fire   = out_valid && out_ready;

        // Slots the buffer will need if a read goes out now: what it holds,
        // minus what decode takes this cycle, plus the response returning
        // now, plus the new read.
        occupancy  = {1'b0, buf_count} + {2'b00, inflight_q} + 3'd1
                   - {2'b00, out_fire};
        issue      = run && !stall && !redirect_valid
                   && (occupancy <= 3'(BUF_DEPTH));

        // A response returning in the redirect cycle is wrong-path, so it is
        // blocked here directly; squash guards the slot after the redirect.
        push       = inflight_q && !squash_q && !redir;
        flush      = redir && !bad_target;

        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        inflight_d = issue;
        squash_d   = 1'b0;

        case (state_q)
            FC_IDLE: state_d = FC_RUN;
            FC_RUN: begin
                if (redir) begin
                    // cur_pc shows the target even when it faults.
                    pc_d = redirect_pc;
                    if (bad_target) begin
                        state_d  = FC_FAULT;
                        squash_d = 1'b1;
                    end else begin
                        squash_d = inflight_q;
                    end
                end else if (issue) begin
                    pc_d   = pc_q + WORD'(PC_INC);
                    addr_d = pc_q;
                end
            end
            FC_FAULT: squash_d = 1'b1;
            default:  state_d = FC_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FC_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    fetch_buf #(
        .W(WORD + INSTR_LEN)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (out_fire),
        .flush (flush),
        .din   ({addr_q, imem_rdata}),
        .dout  (buf_dout),
        .count (buf_count)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign cur_pc    = pc_q;
    assign fault     = (state_q == FC_FAULT);
    assign out_pc    = buf_dout[WORD+INSTR_LEN-1:INSTR_LEN];
    assign out_instr = buf_dout[INSTR_LEN-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. The instruction memory model returns
// addr[31:0] ^ 32'hC0DE_0000 one cycle after each request.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [63:0] cur_pc;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault),
        .cur_pc         (cur_pc)
    );

    // Synchronous instruction memory model.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr[31:0] ^ 32'hC0DE_0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        tick();
        #1;
        checks++;
        if ({imem_req, out_valid, fault} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {imem_req, out_valid, fault});
        else passed++;
        checks++;
        if (out_pc !== 64'h0) $display("FAIL reset_out_pc got %h want 0", out_pc);
        else passed++;
        checks++;
        if (out_instr !== 32'h0) $display("FAIL reset_out_instr got %h want 0", out_instr);
        else passed++;
        checks++;
        if (cur_pc !== 64'h0) $display("FAIL reset_cur_pc got %h want 0", cur_pc);
        else passed++;
        redirect_valid = 1'b0;
        $display("reset: outputs idle, cur_pc=%h", cur_pc);
    endtask

    task automatic test_sequential();
        logic        exp_req   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [63:0] exp_addr  [6] = '{64'h0, 64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
        logic        exp_valid [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] exp_pc    [6] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h4, 64'h8};
        logic [31:0] exp_instr [6] = '{32'h0, 32'h0, 32'h0, 32'hC0DE_0000,
                                       32'hC0DE_0004, 32'hC0DE_0008};
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (imem_req !== exp_req[i])
                $display("FAIL seq_req[%0d] got %b want %b", i, imem_req, exp_req[i]);
            else passed++;
            if (exp_req[i]) begin
                checks++;
                if (imem_addr !== exp_addr[i])
                    $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, exp_addr[i]);
                else passed++;
            end
            checks++;
            if (out_valid !== exp_valid[i])
                $display("FAIL seq_valid[%0d] got %b want %b", i, out_valid, exp_valid[i]);
            else passed++;
            if (exp_valid[i]) begin
                checks++;
                if ({out_pc, out_instr} !== {exp_pc[i], exp_instr[i]})
                    $display("FAIL seq_head[%0d] got %h/%h want %h/%h", i, out_pc, out_instr,
                             exp_pc[i], exp_instr[i]);
                else passed++;
                $display("seq: pop pc=%h instr=%h", out_pc, out_instr);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n_req = 0;
        logic [63:0] exp_pc   [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
        logic [63:0] exp_addr [4] = '{64'h8, 64'hC, 64'h10, 64'h14};
        do_reset();
        out_ready = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_req) n_req++;
            if (i >= 6) begin
                checks++;
                if ({imem_req, out_valid} !== 2'b01)
                    $display("FAIL bp_hold[%0d] got req=%b valid=%b want req=0 valid=1",
                             i, imem_req, out_valid);
                else passed++;
            end
            tick();
        end
        checks++;
        if (n_req !== 2) $display("FAIL bp_req_count got %0d want 2", n_req);
        else passed++;
        $display("bp: %0d requests while decode held off", n_req);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if (!out_valid || out_pc !== exp_pc[j])
                $display("FAIL bp_pop[%0d] got valid=%b pc=%h want pc=%h", j, out_valid, out_pc, exp_pc[j]);
            else passed++;
            checks++;
            if (!imem_req || imem_addr !== exp_addr[j])
                $display("FAIL bp_addr[%0d] got req=%b addr=%h want %h", j, imem_req, imem_addr, exp_addr[j]);
            else passed++;
            $display("bp: pop pc=%h, request addr=%h", out_pc, imem_addr);
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        // Buffer holds pc 0, read of pc 4 returning now; decode not taking.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        #1;
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 64'h0})
            $display("FAIL redir_pre got valid=%b pc=%h want 1/0", out_valid, out_pc);
        else passed++;
        checks++;
        if (imem_req !== 1'b0) $display("FAIL redir_noreq got %b want 0", imem_req);
        else passed++;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        checks++;
        if ({out_valid, imem_req, imem_addr} !== {2'b01, 64'h100})
            $display("FAIL redir_target got valid=%b req=%b addr=%h want 0/1/100",
                     out_valid, imem_req, imem_addr);
        else passed++;
        tick();
        #1;
        checks++;
        if ({out_valid, imem_req, imem_addr} !== {2'b01, 64'h104})
            $display("FAIL redir_next got valid=%b req=%b addr=%h want 0/1/104",
                     out_valid, imem_req, imem_addr);
        else passed++;
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h100, 32'hC0DE_0100})
            $display("FAIL redir_head got valid=%b pc=%h instr=%h want 1/100/c0de0100",
                     out_valid, out_pc, out_instr);
        else passed++;
        $display("redir: pop pc=%h instr=%h", out_pc, out_instr);
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 64'h104})
            $display("FAIL redir_head2 got valid=%b pc=%h want 1/104", out_valid, out_pc);
        else passed++;
        $display("redir: pop pc=%h instr=%h", out_pc, out_instr);
    endtask

    task automatic test_fault();
        do_reset();
        out_ready = 1'b0;
        rst_n     = 1'b1;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        #1;
        checks++;
        if ({imem_req, fault} !== 2'b00)
            $display("FAIL fault_entry got req=%b fault=%b want 0/0", imem_req, fault);
        else passed++;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        checks++;
        if ({fault, imem_req, out_valid, out_pc} !== {3'b101, 64'h0})
            $display("FAIL fault_set got fault=%b req=%b valid=%b pc=%h want 1/0/1/0",
                     fault, imem_req, out_valid, out_pc);
        else passed++;
        checks++;
        if (cur_pc !== 64'h102) $display("FAIL fault_cur_pc got %h want 102", cur_pc);
        else passed++;
        tick();
        #1;
        checks++;
        if ({fault, imem_req, out_valid, out_pc} !== {3'b101, 64'h4})
            $display("FAIL fault_drain got fault=%b req=%b valid=%b pc=%h want 1/0/1/4",
                     fault, imem_req, out_valid, out_pc);
        else passed++;
        // A later well-formed redirect must not revive fetching.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if ({fault, imem_req, out_valid} !== 3'b100)
                $display("FAIL fault_hold[%0d] got fault=%b req=%b valid=%b want 1/0/0",
                         i, fault, imem_req, out_valid);
            else passed++;
        end
        redirect_valid = 1'b0;
        $display("fault: sticky, cur_pc=%h", cur_pc);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fault, cur_pc} !== {1'b0, 64'h0})
            $display("FAIL fault_clear got fault=%b cur_pc=%h want 0/0", fault, cur_pc);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        rst_n = 1'b1;
        repeat (5) tick();
        stall = 1'b1;
        #1;
        checks++;
        if ({imem_req, out_valid, out_pc} !== {2'b01, 64'h8})
            $display("FAIL stall_c0 got req=%b valid=%b pc=%h want 0/1/8", imem_req, out_valid, out_pc);
        else passed++;
        tick();
        #1;
        checks++;
        if ({imem_req, out_valid, out_pc, out_instr} !== {2'b01, 64'hC, 32'hC0DE_000C})
            $display("FAIL stall_c1 got req=%b valid=%b pc=%h instr=%h want 0/1/c/c0de000c",
                     imem_req, out_valid, out_pc, out_instr);
        else passed++;
        $display("stall: in-flight response pc=%h delivered", out_pc);
        tick();
        #1;
        checks++;
        if ({imem_req, out_valid} !== 2'b00)
            $display("FAIL stall_c2 got req=%b valid=%b want 0/0", imem_req, out_valid);
        else passed++;
        tick();
        stall = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, out_valid} !== {1'b1, 64'h10, 1'b0})
            $display("FAIL stall_resume got req=%b addr=%h valid=%b want 1/10/0",
                     imem_req, imem_addr, out_valid);
        else passed++;
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h14})
            $display("FAIL stall_next got req=%b addr=%h want 1/14", imem_req, imem_addr);
        else passed++;
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 64'h10})
            $display("FAIL stall_head got valid=%b pc=%h want 1/10", out_valid, out_pc);
        else passed++;
        $display("stall: resumed, pop pc=%h", out_pc);
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        rst_n = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, out_valid} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0})
            $display("FAIL wrap_target got req=%b addr=%h valid=%b want 1/fffffffffffffffc/0",
                     imem_req, imem_addr, out_valid);
        else passed++;
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr, cur_pc} !== {1'b1, 64'h0, 64'h0})
            $display("FAIL wrap_zero got req=%b addr=%h cur_pc=%h want 1/0/0", imem_req, imem_addr, cur_pc);
        else passed++;
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h3F21_FFFC})
            $display("FAIL wrap_head got valid=%b pc=%h instr=%h want 1/fffffffffffffffc/3f21fffc",
                     out_valid, out_pc, out_instr);
        else passed++;
        $display("wrap: pop pc=%h instr=%h", out_pc, out_instr);
        tick();
        #1;
        checks++;
        if ({out_pc, imem_addr} !== {64'h0, 64'h8})
            $display("FAIL wrap_head2 got pc=%h addr=%h want 0/8", out_pc, imem_addr);
        else passed++;
        // Asynchronous reset in mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, out_valid, fault} !== 3'b000)
            $display("FAIL async_flags got %b want 000", {imem_req, out_valid, fault});
        else passed++;
        checks++;
        if ({out_pc, out_instr, cur_pc} !== {64'h0, 32'h0, 64'h0})
            $display("FAIL async_data got pc=%h instr=%h cur_pc=%h want 0/0/0", out_pc, out_instr, cur_pc);
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) $display("FAIL restart_idle got %b want 0", imem_req);
        else passed++;
        tick();
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h0})
            $display("FAIL restart_first got req=%b addr=%h want 1/0", imem_req, imem_addr);
        else passed++;
        tick();
        tick();
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'h0, 32'hC0DE_0000})
            $display("FAIL restart_head got valid=%b pc=%h instr=%h want 1/0/c0de0000",
                     out_valid, out_pc, out_instr);
        else passed++;
        $display("restart: pop pc=%h instr=%h", out_pc, out_instr);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_fault();
        test_stall();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish within 100000");
        $fatal(1, "time limit reached");
    end

endmodule
